// File: rtl/pc_redirect_unit.sv
// Program-counter block for the single-cycle RV32I core. It resolves branch, jump and
// mret redirects, traps on misaligned targets, and supports stall, an EBREAK halt and instret.
module pc_redirect_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0]  TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             jal,
  input  logic             jalr,
  input  logic             mret,
  input  logic             ebreak,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             trap,
  output logic [XLEN-1:0]  epc_out,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc, pc_next;
  logic [XLEN-1:0]   epc, epc_next;
  logic [CNT_W-1:0]  cnt, cnt_next;

  logic              taken;
  logic              redirect;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   jalr_sum;
  logic              active;

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // Redirect target ignores mret: the mret path reloads epc, which is always aligned.
  always_comb begin
    jalr_sum = rs1_val + imm;
    redirect = 1'b0;
    target   = pc + imm;
    if (jalr) begin
      redirect = 1'b1;
      target   = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (jal || (branch && taken)) begin
      redirect = 1'b1;
    end
  end

  assign active = (state == S_RUN) && !stall;
  assign trap   = active && !mret && redirect && (target[1:0] != 2'b00);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    epc_next   = epc;
    cnt_next   = cnt;
    unique case (state)
      S_RUN: begin
        if (!stall) begin
          if (ebreak) begin
            state_next = S_HALT;
          end else if (trap) begin
            pc_next  = TRAP_VEC;
            epc_next = pc;
          end else begin
            cnt_next = cnt + CNT_W'(1);
            if (mret)          pc_next = epc;
            else if (redirect) pc_next = target;
            else               pc_next = pc + XLEN'(4);
          end
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      pc    <= RESET_VEC;
      epc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      epc   <= epc_next;
      cnt   <= cnt_next;
    end
  end

  assign pc_out   = pc;
  assign pc_plus4 = pc + XLEN'(4);
  assign epc_out  = epc;
  assign halted   = (state == S_HALT);
  assign instret  = cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed walk through the redirect, trap, stall and halt
// behaviour, then random stimulus against an architectural PC model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, zero, lt, ltu, jal, jalr, mret, ebreak;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_val;
  logic [31:0] pc_out, pc_plus4, epc_out, instret;
  logic        trap, halted;
  logic [31:0] pc_out_s, pc_plus4_s, epc_out_s;
  logic [3:0]  instret_s;
  logic        trap_s, halted_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_epc, m_cnt;
  logic        m_halt;

  always #5 clk = ~clk;

  pc_redirect_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .jal(jal), .jalr(jalr), .mret(mret),
    .ebreak(ebreak), .imm(imm), .rs1_val(rs1_val), .pc_out(pc_out),
    .pc_plus4(pc_plus4), .trap(trap), .epc_out(epc_out), .halted(halted),
    .instret(instret)
  );

  pc_redirect_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .jal(jal), .jalr(jalr), .mret(mret),
    .ebreak(ebreak), .imm(imm), .rs1_val(rs1_val), .pc_out(pc_out_s),
    .pc_plus4(pc_plus4_s), .trap(trap_s), .epc_out(epc_out_s), .halted(halted_s),
    .instret(instret_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_taken();
    case (funct3)
      3'd0:    return zero;
      3'd1:    return !zero;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      3'd7:    return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Architectural view of one instruction: where does it send the PC, and does it fault.
  function automatic logic model_trap();
    logic [31:0] t;
    if (m_halt || stall || mret) return 1'b0;
    if (jalr) begin
      t = (rs1_val + imm) & 32'hFFFF_FFFE;
      return (t % 4) != 0;
    end
    if (jal || (branch && cond_taken())) begin
      t = m_pc + imm;
      return (t % 4) != 0;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_next_pc();
    if (mret)                         return m_epc;
    if (jalr)                         return (rs1_val + imm) & 32'hFFFF_FFFE;
    if (jal || (branch && cond_taken())) return m_pc + imm;
    return m_pc + 4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_cnt = 32'h0; m_halt = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc_out"},   {32'h0, pc_out},    {32'h0, m_pc});
    check({tag, ".epc_out"},  {32'h0, epc_out},   {32'h0, m_epc});
    check({tag, ".halted"},   {63'h0, halted},    {63'h0, m_halt});
    check({tag, ".instret"},  {32'h0, instret},   {32'h0, m_cnt});
    check({tag, ".instret4"}, {60'h0, instret_s}, {60'h0, m_cnt[3:0]});
  endtask

  task automatic clear_ctl();
    stall = 0; branch = 0; funct3 = 3'd0; zero = 0; lt = 0; ltu = 0;
    jal = 0; jalr = 0; mret = 0; ebreak = 0; imm = 32'h0; rs1_val = 32'h0;
  endtask

  // Inputs are driven just after an edge; trap is sampled mid-cycle, registers just after the next edge.
  task automatic step(input string tag);
    logic t;
    #1;
    t = model_trap();
    check({tag, ".trap"},     {63'h0, trap},     {63'h0, t});
    check({tag, ".pc_plus4"}, {32'h0, pc_plus4}, {32'h0, m_pc + 32'd4});
    @(posedge clk);
    if (!m_halt && !stall) begin
      if (ebreak) m_halt = 1'b1;
      else if (t) begin
        m_epc = m_pc; m_pc = 32'h100;
      end else begin
        m_pc = model_next_pc(); m_cnt = m_cnt + 1;
      end
    end
    #1;
    check_regs(tag);
  endtask

  task automatic goto(input logic [31:0] target);
    clear_ctl();
    jal = 1; imm = target - m_pc;
    step("goto");
    clear_ctl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_ctl();
    reset = 0;
    model_reset();
    #2;
    check_regs("reset");
    check("reset.pc_plus4", {32'h0, pc_plus4}, 64'h4);
    #5 reset = 1;            // released away from any edge
    @(posedge clk); #1;      // first edge after release retires one instruction
    m_pc = 32'h4; m_cnt = 1;
    check_regs("seq1");
    step("seq2");
    step("seq3");
    check("seq.pc_c",   {32'h0, pc_out},  64'hC);
    check("seq.cnt3",   {32'h0, instret}, 64'h3);

    // conditional branches from pc=0x10
    goto(32'h10); branch = 1; funct3 = 3'b000; zero = 1; imm = 32'hFFFF_FFF8; step("beq_t");
    check("beq_t.pc", {32'h0, pc_out}, 64'h8);
    goto(32'h10); branch = 1; funct3 = 3'b000; zero = 0; imm = 32'hFFFF_FFF8; step("beq_nt");
    check("beq_nt.pc", {32'h0, pc_out}, 64'h14);
    goto(32'h10); branch = 1; funct3 = 3'b110; ltu = 1; imm = 32'h20; step("bltu");
    check("bltu.pc", {32'h0, pc_out}, 64'h30);
    goto(32'h10); branch = 1; funct3 = 3'b010; zero = 1; lt = 1; ltu = 1; imm = 32'h20;
    step("f3_010");
    check("f3_010.pc", {32'h0, pc_out}, 64'h14);

    // jalr and combined controls
    goto(32'h20); jalr = 1; rs1_val = 32'h1005; step("jalr");
    check("jalr.pc", {32'h0, pc_out}, 64'h1004);
    goto(32'h20); jal = 1; branch = 1; funct3 = 3'b000; zero = 1; imm = 32'h40; step("jal_br");
    check("jal_br.pc", {32'h0, pc_out}, 64'h60);

    // misaligned trap and return
    goto(32'h20); jalr = 1; rs1_val = 32'h102;
    #1 check("mis.trap_now", {63'h0, trap}, 64'h1);
    step("mis");
    check("mis.pc",  {32'h0, pc_out},  64'h100);
    check("mis.epc", {32'h0, epc_out}, 64'h20);
    clear_ctl(); mret = 1; step("mret");
    check("mret.pc", {32'h0, pc_out}, 64'h20);

    // stall holds a pending jal
    goto(32'h30); stall = 1; jal = 1; imm = 32'h80;
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.pc", {32'h0, pc_out}, 64'h30);
    stall = 0; step("unstall");
    check("unstall.pc", {32'h0, pc_out}, 64'hB0);

    // halt, then asynchronous reset between edges
    goto(32'h40); ebreak = 1; step("ebreak");
    check("ebreak.halted", {63'h0, halted}, 64'h1);
    clear_ctl(); jal = 1; imm = 32'h8;
    for (int i = 0; i < 10; i++) step("halt");
    check("halt.pc", {32'h0, pc_out}, 64'h40);
    #2 reset = 0; #1;
    model_reset();
    check("areset.pc",     {32'h0, pc_out}, 64'h0);
    check("areset.halted", {63'h0, halted}, 64'h0);
    clear_ctl();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    m_pc = 32'h4; m_cnt = 1;
    check_regs("rel");
    for (int i = 0; i < 16; i++) step("wrap");
    check("wrap.cnt4", {60'h0, instret_s}, 64'h1);

    // random phase
    for (int i = 0; i < 600; i++) begin
      clear_ctl();
      if (m_halt && $urandom_range(0, 3) == 0) begin
        #2 reset = 0; #1;
        model_reset();
        check_regs("rnd_rst");
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        m_pc = 32'h4; m_cnt = 1;
        check_regs("rnd_rel");
        continue;
      end
      stall   = ($urandom_range(0, 3) == 0);
      branch  = ($urandom_range(0, 2) == 0);
      funct3  = 3'($urandom_range(0, 7));
      zero    = 1'($urandom);
      lt      = 1'($urandom);
      ltu     = 1'($urandom);
      jal     = ($urandom_range(0, 5) == 0);
      jalr    = ($urandom_range(0, 5) == 0);
      mret    = ($urandom_range(0, 7) == 0);
      ebreak  = ($urandom_range(0, 60) == 0);
      imm     = $urandom & ((($urandom_range(0, 3) == 0)) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      rs1_val = $urandom;
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Parametrised next-generation program-counter block for the single-cycle RV32I core.
- Holds the PC register and resolves every redirect internally: all six conditional branches, JAL, JALR, MRET, and a trap on a misaligned target. Sequential PC+4 is the default.
- Also supports pipeline stalls, an EBREAK halt state and a retired-instruction counter.
- Sits between the control unit/ALU and instruction memory. It replaces the sequential-only PC path.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_VEC, 32'h0000_0000, PC value after reset. Must be 4-byte aligned.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap. Must be 4-byte aligned.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  single clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold all state this cycle.
- branch  in  1  current instruction is a conditional branch.
- funct3  in  3  branch condition select.
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- jal  in  1  current instruction is JAL.
- jalr  in  1  current instruction is JALR.
- mret  in  1  current instruction is MRET.
- ebreak  in  1  current instruction is EBREAK.
- imm  in  XLEN  sign-extended immediate, byte offset, unshifted.
- rs1_val  in  XLEN  rs1 operand for JALR.
- pc_out  out  XLEN  current PC to instruction memory.
- pc_plus4  out  XLEN  pc_out+4, used as the link value.
- trap  out  1  misaligned-target trap, combinational.
- epc_out  out  XLEN  saved exception PC.
- halted  out  1  block is in the HALT state.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (reset=0, takes effect asynchronously and immediately):
  - pc = RESET_VEC, epc = 0, instret = 0.
  - state = RUN, halted = 0.
  - Reset asserted mid-operation overrides everything.
- States:
  - RUN to HALT on an edge with ebreak=1, stall=0.
  - HALT is left only by reset.
  - In HALT: pc, epc and instret are frozen, trap=0, and all inputs are ignored.
- Arithmetic: all adds are modulo 2^XLEN. pc_plus4 = pc+4.
- Branch condition by funct3:
  - 000 zero; 001 !zero.
  - 100 lt; 101 !lt.
  - 110 ltu; 111 !ltu.
  - 010 and 011 are never taken.
- Targets:
  - branch/jal: pc+imm.
  - jalr: (rs1_val+imm) with bit0 cleared.
  - mret: epc.
- Next-PC priority: mret > jalr > jal > taken branch > pc+4.
- Misaligned trap:
  - Condition: state RUN, stall=0, and the selected redirect target (jalr, jal, or taken branch) has bits[1:0] != 0.
  - trap=1 in that same cycle.
  - At the edge: pc <= TRAP_VEC, epc <= pc of the faulting instruction, instret unchanged.
  - PC+4 and mret paths never trap.
- Stall:
  - pc, epc, instret and state hold; trap forced to 0.
  - ebreak under stall is ignored until stall drops.
- instret:
  - +1 on each edge in RUN with stall=0, trap=0 and ebreak=0.
  - Wraps from 2^CNT_W-1 to 0.
- Outputs pc_out, epc_out, instret and halted come directly from registers. The next-PC mux is combinational, so there is no added latency: a redirect is visible on pc_out one edge after the instruction.

Test Plan:
1. Reset then release, RESET_VEC=0, no controls asserted -> pc_out 0,4,8,C on successive edges; instret=3 after the third edge.
2. Conditional branches:
   - pc=0x10, branch=1, funct3=000, zero=1, imm=0xFFFFFFF8 -> next pc 0x08.
   - Same with zero=0 -> 0x14.
   - funct3=110, ltu=1, imm=0x20 at pc=0x10 -> 0x30.
   - funct3=010 -> 0x14.
3. JALR and combined controls:
   - JALR at pc=0x20, rs1_val=0x1005, imm=0 -> next pc 0x1004, no trap.
   - jal=1 and branch taken together, imm=0x40 at pc=0x20 -> 0x60.
4. Misaligned trap and return:
   - JALR at pc=0x20, rs1_val=0x102, imm=0 -> trap=1 same cycle; next pc 0x100, epc_out=0x20, instret unchanged.
   - Then mret -> pc 0x20.
5. Stall: jal=1, imm=0x80 at pc=0x30 with stall=1 for 3 edges -> pc 0x30 and instret held; stall=0 -> pc 0xB0.
6. Halt and reset:
   - ebreak at pc=0x40 -> halted=1 next edge; pc stays 0x40 and instret frozen for 10 edges despite jal=1.
   - Drop reset asynchronously between edges -> pc_out=0 and halted=0 immediately.
   - With CNT_W=4, 16 retirements -> instret wraps to 0.
